// File: rtl/custom_leds_gpio_ctrl.sv
// Avalon-MM LED + GPIO peripheral: per-LED blink, global PWM dimming, per-pin GPIO direction,
// synchronised GPIO input with sticky rising-edge capture and a maskable level interrupt.
module custom_leds_gpio_ctrl #(
    parameter int NUM_LEDS   = 8,
    parameter int GPIO_WIDTH = 36,
    parameter int PWM_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [NUM_LEDS-1:0]   leds,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic                  irq
);
    // control / status registers
    logic [NUM_LEDS-1:0]   r_led_out;
    logic [NUM_LEDS-1:0]   r_blink_en;
    logic [23:0]           r_blink_period;
    logic [PWM_BITS-1:0]   r_pwm_duty;
    logic [GPIO_WIDTH-1:0] r_gpio_out;
    logic [GPIO_WIDTH-1:0] r_gpio_dir;
    logic [GPIO_WIDTH-1:0] r_edge_cap;
    logic [GPIO_WIDTH-1:0] r_irq_mask;

    // timing and input pipeline
    logic [23:0]           r_blink_cnt;
    logic                  r_blink_phase;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [GPIO_WIDTH-1:0] r_sync1;
    logic [GPIO_WIDTH-1:0] r_sync2;
    logic [GPIO_WIDTH-1:0] r_hist;

    // registered outputs
    logic [NUM_LEDS-1:0]   r_leds;
    logic                  r_irq;
    logic [31:0]           r_readdata;
    logic                  r_readdatavalid;

    logic [15:0]           w_wr_sel;
    logic [GPIO_WIDTH-1:0] w_gpio_out_next;
    logic [GPIO_WIDTH-1:0] w_gpio_dir_next;
    logic [GPIO_WIDTH-1:0] w_irq_mask_next;
    logic [GPIO_WIDTH-1:0] w_edge_cap_next;
    logic                  w_pwm_on;
    logic [63:0]           w_gpio_out_pad;
    logic [63:0]           w_gpio_dir_pad;
    logic [63:0]           w_gpio_in_pad;
    logic [63:0]           w_edge_cap_pad;
    logic [63:0]           w_irq_mask_pad;
    logic [31:0]           w_rd_mux;

    assign w_wr_sel = avs_write ? (16'd1 << avs_address) : 16'd0;

    // Pins 0..31 live in the LO word, 32..63 in the HI word (the following address).
    genvar gi;
    generate
        for (gi = 0; gi < GPIO_WIDTH; gi++) begin : g_gpio_bit
            localparam int HALF = gi / 32;
            localparam int BIT  = gi % 32;
            logic w_rise;
            logic w_clear;
            assign w_gpio_out_next[gi] = w_wr_sel[4 + HALF]  ? avs_writedata[BIT] : r_gpio_out[gi];
            assign w_gpio_dir_next[gi] = w_wr_sel[6 + HALF]  ? avs_writedata[BIT] : r_gpio_dir[gi];
            assign w_irq_mask_next[gi] = w_wr_sel[12 + HALF] ? avs_writedata[BIT] : r_irq_mask[gi];
            assign w_rise  = r_sync2[gi] & ~r_hist[gi];
            assign w_clear = w_wr_sel[10 + HALF] & avs_writedata[BIT];
            // a new edge beats a simultaneous W1C so no event is ever lost
            assign w_edge_cap_next[gi] = w_rise | (r_edge_cap[gi] & ~w_clear);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led_out      <= '0;
            r_blink_en     <= '0;
            r_blink_period <= '0;
            r_pwm_duty     <= '1;
            r_gpio_out     <= '0;
            r_gpio_dir     <= '0;
            r_irq_mask     <= '0;
            r_edge_cap     <= '0;
        end else begin
            if (w_wr_sel[0]) r_led_out      <= avs_writedata[NUM_LEDS-1:0];
            if (w_wr_sel[1]) r_blink_en     <= avs_writedata[NUM_LEDS-1:0];
            if (w_wr_sel[2]) r_blink_period <= avs_writedata[23:0];
            if (w_wr_sel[3]) r_pwm_duty     <= avs_writedata[PWM_BITS-1:0];
            r_gpio_out <= w_gpio_out_next;
            r_gpio_dir <= w_gpio_dir_next;
            r_irq_mask <= w_irq_mask_next;
            r_edge_cap <= w_edge_cap_next;
        end
    end

    // Blink timebase restarts from phase 0 whenever the period is rewritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wr_sel[2] || (r_blink_period == 24'd0)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == r_blink_period - 24'd1) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 24'd1;
        end
    end

    assign w_pwm_on = (&r_pwm_duty) | (r_pwm_cnt < r_pwm_duty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_hist    <= '0;
            r_leds    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_sync1   <= gpio_in;
            r_sync2   <= r_sync1;
            r_hist    <= r_sync2;
            r_leds    <= (r_led_out ^ (r_blink_en & {NUM_LEDS{r_blink_phase}})) & {NUM_LEDS{w_pwm_on}};
            r_irq     <= |(r_edge_cap & r_irq_mask);
        end
    end

    assign w_gpio_out_pad = 64'(r_gpio_out);
    assign w_gpio_dir_pad = 64'(r_gpio_dir);
    assign w_gpio_in_pad  = 64'(r_sync2);
    assign w_edge_cap_pad = 64'(r_edge_cap);
    assign w_irq_mask_pad = 64'(r_irq_mask);

    always_comb begin
        w_rd_mux = 32'h0;
        case (avs_address)
            4'h0:    w_rd_mux = 32'(r_led_out);
            4'h1:    w_rd_mux = 32'(r_blink_en);
            4'h2:    w_rd_mux = {8'h0, r_blink_period};
            4'h3:    w_rd_mux = 32'(r_pwm_duty);
            4'h4:    w_rd_mux = w_gpio_out_pad[31:0];
            4'h5:    w_rd_mux = w_gpio_out_pad[63:32];
            4'h6:    w_rd_mux = w_gpio_dir_pad[31:0];
            4'h7:    w_rd_mux = w_gpio_dir_pad[63:32];
            4'h8:    w_rd_mux = w_gpio_in_pad[31:0];
            4'h9:    w_rd_mux = w_gpio_in_pad[63:32];
            4'hA:    w_rd_mux = w_edge_cap_pad[31:0];
            4'hB:    w_rd_mux = w_edge_cap_pad[63:32];
            4'hC:    w_rd_mux = w_irq_mask_pad[31:0];
            4'hD:    w_rd_mux = w_irq_mask_pad[63:32];
            default: w_rd_mux = 32'h0;
        endcase
    end

    // The mux sees pre-write register values, so a same-cycle read returns the old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdata      <= avs_read ? w_rd_mux : 32'h0;
            r_readdatavalid <= avs_read;
        end
    end

    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_readdatavalid;
    assign leds              = r_leds;
    assign gpio_out          = r_gpio_out;
    assign gpio_oe           = r_gpio_dir;
    assign irq               = r_irq;
endmodule

// File: tb/tb_custom_leds_gpio_ctrl.sv
// Bench for custom_leds_gpio_ctrl: behavioural model checked every cycle plus directed literal checks.
module tb_custom_leds_gpio_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  avs_address = 4'h0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'h0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [7:0]  leds;
    logic [35:0] gpio_out;
    logic [35:0] gpio_oe;
    logic [35:0] gpio_in = 36'h0;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    custom_leds_gpio_ctrl #(.NUM_LEDS(8), .GPIO_WIDTH(36), .PWM_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .leds(leds), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_led, m_blink_en, m_duty;
    logic [23:0] m_period;
    int          m_age;      // cycles since the blink period was last written
    int          m_cycles;   // cycles since reset
    logic [35:0] m_gout, m_gdir, m_edge, m_mask;
    logic [35:0] m_past[3];  // m_past[0] = pin value sampled at the previous edge
    logic [7:0]  m_exp_leds;
    logic        m_exp_irq, m_exp_rdv;
    logic [31:0] m_exp_rd;

    function automatic logic [7:0] model_leds();
        logic phase;
        logic on;
        phase = (m_period != 24'd0) && (((m_age / int'(m_period)) % 2) == 1);
        on    = (m_duty == 8'hFF) || ((m_cycles % 256) < int'(m_duty));
        return on ? (m_led ^ (phase ? m_blink_en : 8'h00)) : 8'h00;
    endfunction

    function automatic logic [31:0] reg_view(input logic [3:0] a);
        case (a)
            4'h0: return {24'h0, m_led};
            4'h1: return {24'h0, m_blink_en};
            4'h2: return {8'h0, m_period};
            4'h3: return {24'h0, m_duty};
            4'h4: return m_gout[31:0];
            4'h5: return {28'h0, m_gout[35:32]};
            4'h6: return m_gdir[31:0];
            4'h7: return {28'h0, m_gdir[35:32]};
            4'h8: return m_past[1][31:0];
            4'h9: return {28'h0, m_past[1][35:32]};
            4'hA: return m_edge[31:0];
            4'hB: return {28'h0, m_edge[35:32]};
            4'hC: return m_mask[31:0];
            4'hD: return {28'h0, m_mask[35:32]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [35:0] w1c_bits();
        if (avs_write && avs_address == 4'hA) return {4'h0, avs_writedata};
        if (avs_write && avs_address == 4'hB) return {avs_writedata[3:0], 32'h0};
        return 36'h0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_led <= 8'h0; m_blink_en <= 8'h0; m_duty <= 8'hFF; m_period <= 24'h0;
            m_age <= 0; m_cycles <= 0;
            m_gout <= '0; m_gdir <= '0; m_edge <= '0; m_mask <= '0;
            m_past[0] <= '0; m_past[1] <= '0; m_past[2] <= '0;
            m_exp_leds <= 8'h0; m_exp_irq <= 1'b0; m_exp_rdv <= 1'b0; m_exp_rd <= 32'h0;
        end else begin
            m_exp_leds <= model_leds();
            m_exp_irq  <= |(m_edge & m_mask);
            m_exp_rdv  <= avs_read;
            if (avs_read) m_exp_rd <= reg_view(avs_address);
            m_cycles   <= m_cycles + 1;
            m_age      <= (avs_write && avs_address == 4'h2) ? 0 : m_age + 1;
            m_past[0]  <= gpio_in;
            m_past[1]  <= m_past[0];
            m_past[2]  <= m_past[1];
            m_edge     <= (m_edge & ~w1c_bits()) | (m_past[1] & ~m_past[2]);
            if (avs_write) begin
                case (avs_address)
                    4'h0: m_led <= avs_writedata[7:0];
                    4'h1: m_blink_en <= avs_writedata[7:0];
                    4'h2: m_period <= avs_writedata[23:0];
                    4'h3: m_duty <= avs_writedata[7:0];
                    4'h4: m_gout[31:0] <= avs_writedata;
                    4'h5: m_gout[35:32] <= avs_writedata[3:0];
                    4'h6: m_gdir[31:0] <= avs_writedata;
                    4'h7: m_gdir[35:32] <= avs_writedata[3:0];
                    4'hC: m_mask[31:0] <= avs_writedata;
                    4'hD: m_mask[35:32] <= avs_writedata[3:0];
                    default: ;
                endcase
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        check("leds", {56'h0, leds}, {56'h0, m_exp_leds});
        check("gpio_out", {28'h0, gpio_out}, {28'h0, m_gout});
        check("gpio_oe", {28'h0, gpio_oe}, {28'h0, m_gdir});
        check("irq", {63'h0, irq}, {63'h0, m_exp_irq});
        check("readdatavalid", {63'h0, avs_readdatavalid}, {63'h0, m_exp_rdv});
        if (m_exp_rdv) check("readdata", {32'h0, avs_readdata}, {32'h0, m_exp_rd});
    end

    // ---------------- directed stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(posedge clk); #2;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(posedge clk); #2;
        avs_read = 1'b0;
        check("rd_latency1_valid", {63'h0, avs_readdatavalid}, 64'h1);
        d = avs_readdata;
    endtask

    task automatic count_on(input logic [7:0] pattern, output int cnt);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (leds == pattern) cnt++;
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  s[24];
        int          cnt;

        repeat (3) @(posedge clk);
        #2;
        check("reset_leds", {56'h0, leds}, 64'h0);
        check("reset_irq", {63'h0, irq}, 64'h0);
        reset = 1'b0;
        idle(1);

        // 1: LED_OUT write and readback
        wr(4'h0, 32'hA5);
        idle(1);
        check("led_out_drive", {56'h0, leds}, 64'hA5);
        rd(4'h0, d);
        check("led_out_read", {32'h0, d}, 64'hA5);
        rd(4'h3, d);
        check("pwm_duty_reset", {32'h0, d}, 64'hFF);

        // register width / reserved behaviour, same-cycle read+write
        wr(4'h2, 32'hFF123456);
        rd(4'h2, d);
        check("blink_period_width", {32'h0, d}, 64'h123456);
        wr(4'h2, 32'h0);
        wr(4'h5, 32'hFFFFFFFF);
        rd(4'h5, d);
        check("gpio_out_hi_width", {32'h0, d}, 64'hF);
        wr(4'hE, 32'h12345678);
        rd(4'hE, d);
        check("reserved_read", {32'h0, d}, 64'h0);
        avs_address = 4'h0; avs_writedata = 32'h3C; avs_write = 1'b1; avs_read = 1'b1;
        @(posedge clk); #2;
        avs_write = 1'b0; avs_read = 1'b0;
        check("rw_same_addr_old", {32'h0, avs_readdata}, 64'hA5);
        rd(4'h0, d);
        check("rw_same_addr_new", {32'h0, d}, 64'h3C);
        wr(4'h0, 32'hA5);

        // 2: blink low nibble, period 4
        wr(4'h1, 32'h0F);
        wr(4'h2, 32'd4);
        idle(2);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            s[i] = leds;
        end
        @(posedge clk); #2;
        for (int i = 4; i < 24; i++) begin
            check("blink_toggle4", {60'h0, s[i][3:0]}, {60'h0, ~s[i-4][3:0]});
            check("blink_hi_steady", {60'h0, s[i][7:4]}, 64'hA);
        end
        wr(4'h2, 32'd0);
        idle(2);
        check("blink_period0_steady", {56'h0, leds}, 64'hA5);

        // 3: PWM duty cycle
        wr(4'h0, 32'hFF);
        wr(4'h1, 32'h00);
        wr(4'h3, 32'd64);
        idle(2);
        count_on(8'hFF, cnt);
        check("pwm_duty64", 64'(cnt), 64'd64);
        wr(4'h3, 32'd0);
        idle(2);
        count_on(8'hFF, cnt);
        check("pwm_duty0", 64'(cnt), 64'd0);
        wr(4'h3, 32'd255);
        idle(2);
        count_on(8'hFF, cnt);
        check("pwm_duty255", 64'(cnt), 64'd256);

        // 4: GPIO direction/output, input sync, edge capture, irq
        wr(4'h7, 32'hF);
        wr(4'h5, 32'h5);
        check("gpio_oe_hi", {60'h0, gpio_oe[35:32]}, 64'hF);
        check("gpio_out_hi", {60'h0, gpio_out[35:32]}, 64'h5);
        gpio_in[3] = 1'b1;
        idle(2);
        rd(4'h8, d);
        check("gpio_in_sync", {32'h0, d}, 64'h8);
        rd(4'hA, d);
        check("edge_cap_set", {32'h0, d}, 64'h8);
        wr(4'hC, 32'h8);
        idle(1);
        check("irq_masked_on", {63'h0, irq}, 64'h1);
        wr(4'hA, 32'h8);
        check("irq_lat_after_w1c", {63'h0, irq}, 64'h1);
        idle(1);
        check("irq_cleared", {63'h0, irq}, 64'h0);
        rd(4'hA, d);
        check("edge_cap_w1c", {32'h0, d}, 64'h0);

        // 5: edge coinciding with W1C, then falling edge
        gpio_in[0] = 1'b1;
        idle(2);
        wr(4'hA, 32'h1);
        rd(4'hA, d);
        check("edge_set_wins", {32'h0, d}, 64'h1);
        wr(4'hA, 32'h1);
        rd(4'hA, d);
        check("edge_cleared", {32'h0, d}, 64'h0);
        gpio_in[0] = 1'b0;
        idle(4);
        rd(4'hA, d);
        check("falling_no_edge", {32'h0, d}, 64'h0);

        // 6: reset while everything is active
        wr(4'h0, 32'hA5);
        wr(4'h1, 32'hF0);
        wr(4'h2, 32'd3);
        wr(4'h3, 32'h80);
        gpio_in[3] = 1'b0;
        idle(4);
        gpio_in[3] = 1'b1;
        idle(4);
        check("irq_before_reset", {63'h0, irq}, 64'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_leds", {56'h0, leds}, 64'h0);
        check("async_rst_irq", {63'h0, irq}, 64'h0);
        check("async_rst_gpio_oe", {28'h0, gpio_oe}, 64'h0);
        check("async_rst_gpio_out", {28'h0, gpio_out}, 64'h0);
        gpio_in = 36'h0;
        idle(2);
        reset = 1'b0;
        idle(2);
        check("post_rst_leds", {56'h0, leds}, 64'h0);
        rd(4'h3, d);
        check("post_rst_duty", {32'h0, d}, 64'hFF);
        rd(4'h2, d);
        check("post_rst_period", {32'h0, d}, 64'h0);
        rd(4'hC, d);
        check("post_rst_mask", {32'h0, d}, 64'h0);
        rd(4'hA, d);
        check("post_rst_edge", {32'h0, d}, 64'h0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
